// File: rtl/smb_block_fetcher.sv
// Block fetcher between the NTLMv2 packet ROM and the HMAC-MD5 stages.
// It captures the NTLM hash, then streams the user+domain and blob words as valid/ready blocks.
module smb_block_fetcher #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned WORD_W     = 512,
  parameter int unsigned HASH_W     = 128,
  parameter int unsigned HASH_ADDR  = 7,
  parameter int unsigned USER_ADDR  = 0,
  parameter int unsigned BLOB_FIRST = 1,
  parameter int unsigned BLOB_LAST  = 6,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic [HASH_W-1:0] o_ntlm_hash,
  output logic              o_hash_valid,
  output logic [WORD_W-1:0] o_blk_data,
  output logic              o_blk_user,
  output logic              o_blk_last,
  output logic              o_blk_valid,
  input  logic              i_blk_ready
);

  localparam int unsigned NumBlk = BLOB_LAST - BLOB_FIRST + 2;
  localparam int unsigned CntW   = $clog2(NumBlk + 1);
  localparam int unsigned LatW   = $clog2(RD_LAT + 1);

  localparam logic [ADDR_W-1:0] HashAddr = ADDR_W'(HASH_ADDR);
  localparam logic [ADDR_W-1:0] UserAddr = ADDR_W'(USER_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BLOB_LAST);
  localparam logic [LatW-1:0]   LatLoad  = LatW'(RD_LAT);
  localparam logic [CntW-1:0]   CntMax   = CntW'(NumBlk);

  typedef enum logic [1:0] {StIdle, StHash, StStream, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
  logic [LatW-1:0]     r_lat, w_lat_nxt;
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;
  logic [HASH_W-1:0]   r_hash, w_hash_nxt;
  logic                r_hash_valid, w_hash_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [WORD_W-1:0]   r_blk_data, w_blk_data_nxt;
  logic                r_blk_user, w_blk_user_nxt;
  logic                r_blk_last, w_blk_last_nxt;
  logic                r_blk_valid, w_blk_valid_nxt;
  logic [WORD_W-1:0]   r_pf_data, w_pf_data_nxt;
  logic                r_pf_user, w_pf_user_nxt;
  logic                r_pf_last, w_pf_last_nxt;
  logic                r_pf_valid, w_pf_valid_nxt;

  logic              w_hs;
  logic              w_cap;
  logic [ADDR_W-1:0] w_issue_addr;

  assign w_hs  = r_blk_valid & i_blk_ready;
  assign w_cap = (r_lat == LatW'(1));
  // r_cnt counts issued stream fetches; fetch 0 (user word) is issued at hash capture.
  assign w_issue_addr = ADDR_W'(BLOB_FIRST + 32'(r_cnt) - 32'd1);

  always_comb begin
    w_state_nxt      = r_state;
    w_rom_addr_nxt   = r_rom_addr;
    w_lat_nxt        = r_lat;
    w_cnt_nxt        = r_cnt;
    w_hash_nxt       = r_hash;
    w_hash_valid_nxt = r_hash_valid;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_blk_data_nxt   = r_blk_data;
    w_blk_user_nxt   = r_blk_user;
    w_blk_last_nxt   = r_blk_last;
    w_blk_valid_nxt  = r_blk_valid;
    w_pf_data_nxt    = r_pf_data;
    w_pf_user_nxt    = r_pf_user;
    w_pf_last_nxt    = r_pf_last;
    w_pf_valid_nxt   = r_pf_valid;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt      = StHash;
          w_rom_addr_nxt   = HashAddr;
          w_busy_nxt       = 1'b1;
          w_hash_valid_nxt = 1'b0;
          w_lat_nxt        = LatLoad;
        end
      end
      StHash: begin
        if (r_lat != '0) w_lat_nxt = r_lat - LatW'(1);
        if (w_cap) begin
          w_hash_nxt       = i_rom_data[HASH_W-1:0];
          w_hash_valid_nxt = 1'b1;
          w_rom_addr_nxt   = UserAddr;
          w_lat_nxt        = LatLoad;
          w_cnt_nxt        = CntW'(1);
          w_state_nxt      = StStream;
        end
      end
      StStream: begin
        if (r_lat != '0) w_lat_nxt = r_lat - LatW'(1);
        if (w_hs) begin
          w_blk_valid_nxt = r_pf_valid;
          if (r_pf_valid) begin
            w_blk_data_nxt = r_pf_data;
            w_blk_user_nxt = r_pf_user;
            w_blk_last_nxt = r_pf_last;
            w_pf_valid_nxt = 1'b0;
          end
          if (r_blk_last) begin
            w_state_nxt = StDone;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        // rom_addr still names the in-flight fetch, so it tags the captured word.
        if (w_cap) begin
          if (!r_blk_valid || w_hs) begin
            w_blk_data_nxt  = i_rom_data;
            w_blk_user_nxt  = (r_rom_addr == UserAddr);
            w_blk_last_nxt  = (r_rom_addr == LastAddr);
            w_blk_valid_nxt = 1'b1;
          end else begin
            w_pf_data_nxt  = i_rom_data;
            w_pf_user_nxt  = (r_rom_addr == UserAddr);
            w_pf_last_nxt  = (r_rom_addr == LastAddr);
            w_pf_valid_nxt = 1'b1;
          end
        end
        if ((r_lat <= LatW'(1)) && (r_cnt != CntMax) && !w_pf_valid_nxt) begin
          w_rom_addr_nxt = w_issue_addr;
          w_cnt_nxt      = r_cnt + CntW'(1);
          w_lat_nxt      = LatLoad;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_rom_addr   <= '0;
      r_lat        <= '0;
      r_cnt        <= '0;
      r_hash       <= '0;
      r_hash_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_blk_data   <= '0;
      r_blk_user   <= 1'b0;
      r_blk_last   <= 1'b0;
      r_blk_valid  <= 1'b0;
      r_pf_data    <= '0;
      r_pf_user    <= 1'b0;
      r_pf_last    <= 1'b0;
      r_pf_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rom_addr   <= w_rom_addr_nxt;
      r_lat        <= w_lat_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hash       <= w_hash_nxt;
      r_hash_valid <= w_hash_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_blk_data   <= w_blk_data_nxt;
      r_blk_user   <= w_blk_user_nxt;
      r_blk_last   <= w_blk_last_nxt;
      r_blk_valid  <= w_blk_valid_nxt;
      r_pf_data    <= w_pf_data_nxt;
      r_pf_user    <= w_pf_user_nxt;
      r_pf_last    <= w_pf_last_nxt;
      r_pf_valid   <= w_pf_valid_nxt;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_rom_addr   = r_rom_addr;
  assign o_ntlm_hash  = r_hash;
  assign o_hash_valid = r_hash_valid;
  assign o_blk_data   = r_blk_data;
  assign o_blk_user   = r_blk_user;
  assign o_blk_last   = r_blk_last;
  assign o_blk_valid  = r_blk_valid;

endmodule

// File: doc/smb_block_fetcher.md
Name: smb_block_fetcher

Overview:
Sequencer directly downstream of the NTLMv2 packet ROM. On `start` it reads the 128-bit NTLM hash word from the ROM and holds it for the HMAC-MD5 key stage. It then streams the user+domain word and the blob words, in address order, as 512-bit blocks over a valid/ready handshake to the HMAC message-block stage. It hides the ROM's registered read latency and provides a one-entry prefetch buffer.

Parameters:
ADDR_W, 3, ROM address width.
WORD_W, 512, ROM word and output block width.
HASH_W, 128, NTLM hash width, taken from bits [HASH_W-1:0] of the hash word.
HASH_ADDR, 7, ROM address of the NTLM hash.
USER_ADDR, 0, ROM address of the user+domain word.
BLOB_FIRST, 1, first blob address.
BLOB_LAST, 6, last blob address.
RD_LAT, 2, clock edges from a `rom_addr` update to valid `rom_data` capture (1 for the registered `rom_addr` plus 1 for the ROM output register).

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request, sampled only in IDLE
busy  out  1  high from the edge that accepts `start` until `done`
done  out  1  one-cycle pulse after the last block handshake
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  WORD_W  ROM `DataO`
ntlm_hash  out  HASH_W  captured hash
hash_valid  out  1  `ntlm_hash` is valid
blk_data  out  WORD_W  output block
blk_user  out  1  current block is the user+domain word
blk_last  out  1  current block is the BLOB_LAST word
blk_valid  out  1  block valid
blk_ready  in  1  consumer accepts when `blk_valid` and `blk_ready` are both high

Behaviour:
- Reset (async, reset=0):
  - `state`=IDLE.
  - All outputs are 0, including `rom_addr`, `ntlm_hash`, `hash_valid`, `blk_*`, `busy` and `done`.
  - The prefetch buffer is emptied and the latency counter is cleared.
  - Reset mid-operation discards everything; nothing resumes when reset is released.
- States:
  - IDLE -> HASH on `start`.
  - HASH -> STREAM on the hash capture.
  - STREAM -> DONE after the BLOB_LAST handshake.
  - DONE -> IDLE after one cycle, with `done`=1 in that cycle.
- Edge accepting `start` (e0):
  - `rom_addr`<=HASH_ADDR, `busy`<=1, `hash_valid`<=0.
  - Latency counter loads RD_LAT.
- Latency counter:
  - Decrements each edge while a fetch is in flight.
  - Data is captured from `rom_data` on edge e0+RD_LAT, i.e. when the counter reaches 1 -> 0.
- Hash capture (edge e0+RD_LAT):
  - `ntlm_hash`<=`rom_data`[HASH_W-1:0] and `hash_valid`<=1.
  - `hash_valid` stays 1 until the next accepted `start` or reset.
  - The same edge issues `rom_addr`<=USER_ADDR.
- STREAM fetch order: USER_ADDR, then BLOB_FIRST..BLOB_LAST in ascending order (7 blocks with defaults).
- Fetch issue rule: a new `rom_addr` is issued only when all of these hold:
  - no fetch is in flight;
  - addresses remain;
  - the prefetch buffer is empty.

  At most one fetch is in flight. This guarantees every capture has a free slot.
- Capture routing:
  - If the output register is empty, or is being handshaked on the same edge, the word goes to the output register.
  - Otherwise it goes to the prefetch buffer.
- Handshake:
  - When the output is accepted and the prefetch buffer is full, the prefetch word moves to the output on that same edge, keeping `blk_valid`=1.
  - `blk_data`, `blk_user` and `blk_last` are stable while `blk_valid`=1 and `blk_ready`=0.
- Tags travel with each word:
  - `blk_user`=1 only for USER_ADDR.
  - `blk_last`=1 only for BLOB_LAST.
- Throughput with `blk_ready` held at 1: one block every RD_LAT cycles.
- Backpressure:
  - At most 2 words are held (output register plus prefetch buffer).
  - `rom_addr` holds its value while fetch issue is blocked.
- `done`:
  - Pulses on the edge after the BLOB_LAST handshake.
  - `busy`<=0 on the same edge.
- `start` while busy is ignored and `start` in DONE is ignored; IDLE is re-entered before a new `start` is accepted.
- `rom_addr` never exceeds BLOB_LAST during STREAM, so `rom_data` is never z during capture.

Test Plan:
- Reset release, `start` pulse, `blk_ready`=1 -> `hash_valid` rises at e0+2 with `ntlm_hash`=128'h7a7315c2a0195d74381fff267cc6a15e. Blocks are accepted in address order 0,1..6. The first block is Mem[0] with `blk_user`=1. The last is Mem[6]=…0000000000000000 with `blk_last`=1. `done` is a single pulse; 7 handshakes total.
- `blk_ready`=0 for 12 cycles after the first block becomes valid -> `blk_data` stays at Mem[0]. Exactly one further word (Mem[1]) is captured into the prefetch buffer and `rom_addr` holds 1. After release, Mem[1] is presented on the next cycle with no lost or duplicated blocks.
- `blk_ready` toggling 1,0,1,0 throughout -> the 7 blocks arrive in order, tags are correct, and `done` follows the 7th accept.
- `start` reasserted mid-stream and in the DONE cycle -> ignored, with the sequence and `hash_valid` unaffected. `start` in IDLE afterwards clears `hash_valid` at the accepting edge and restarts the full sequence.
- `reset` asserted after the 3rd handshake -> all outputs are 0 immediately. After release, no activity occurs until `start`; a fresh run is then a complete 7-block sequence.
- RD_LAT=3 build -> hash captured at e0+3, block spacing 3 cycles with `blk_ready`=1, same data and order.
